// File: rtl/xpmwrap_ram_port_ctrl.sv
// Request/response front end for one XPM RAM port: registered RAM drive, latency tracking, and
// an in-order response FIFO. Define XPMWRAP_RAM_PORT_CTRL_WR_ACK_EN to also acknowledge writes.
`timescale 1ns/1ps
module xpmwrap_ram_port_ctrl #(
  parameter int unsigned ADDR_WIDTH       = 6,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BYTE_WRITE_WIDTH = 8,
  parameter int unsigned READ_LATENCY     = 2,
  parameter int unsigned RSP_FIFO_DEPTH   = 8,
  localparam int unsigned NB              = DATA_WIDTH / BYTE_WRITE_WIDTH
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NB-1:0]         req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_wr,
  output logic                  ram_en,
  output logic [NB-1:0]         ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_regce,
  output logic                  ram_rst,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int unsigned PtrW = $clog2(RSP_FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(RSP_FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] Depth = CntW'(RSP_FIFO_DEPTH);

  logic                  en_q, en_d;
  logic [NB-1:0]         we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  iss_q, iss_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CntW-1:0]       out_q, out_d;
`ifdef XPMWRAP_RAM_PORT_CTRL_WR_ACK_EN
  logic                      iss_wr_q, iss_wr_d;
  logic [READ_LATENCY-1:0]   pipe_wr_q, pipe_wr_d;
  logic [RSP_FIFO_DEPTH-1:0] memwr_q, memwr_d;
`endif

  logic accept, rsp_gen, push, pop;

  // Outstanding covers both in-flight reads and FIFO entries, so the FIFO can never overflow.
  assign req_ready = (out_q < Depth) && !rsta;
  assign accept    = req_valid && req_ready;
`ifdef XPMWRAP_RAM_PORT_CTRL_WR_ACK_EN
  assign rsp_gen   = accept;
`else
  assign rsp_gen   = accept && !req_we;
`endif
  assign push      = pipe_q[READ_LATENCY-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? mem_q[rptr_q] : '0;
`ifdef XPMWRAP_RAM_PORT_CTRL_WR_ACK_EN
  assign rsp_wr    = rsp_valid && memwr_q[rptr_q];
`else
  assign rsp_wr    = 1'b0;
`endif

  assign ram_en    = en_q;
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_din   = din_q;
  assign ram_regce = 1'b1;
  assign ram_rst   = rsta;

  always_comb begin
    en_d   = accept;
    we_d   = (accept && req_we) ? req_be : '0;
    addr_d = accept ? req_addr : addr_q;
    din_d  = accept ? req_wdata : din_q;
    iss_d  = rsp_gen;

    // pipe bit 0 is set the cycle after the RAM sees the request; the last bit marks ram_dout valid
    pipe_d[0] = iss_q;
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (push) begin
      mem_d[wptr_q] = ram_dout;
      wptr_d        = wptr_q + 1'b1;
    end
`ifdef XPMWRAP_RAM_PORT_CTRL_WR_ACK_EN
    iss_wr_d     = accept && req_we;
    pipe_wr_d[0] = iss_wr_q;
    for (int i = 1; i < READ_LATENCY; i++) pipe_wr_d[i] = pipe_wr_q[i-1];
    memwr_d = memwr_q;
    if (push) begin
      memwr_d[wptr_q] = pipe_wr_q[READ_LATENCY-1];
      if (pipe_wr_q[READ_LATENCY-1]) mem_d[wptr_q] = '0;
    end
`endif
    if (pop) rptr_d = rptr_q + 1'b1;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    case ({rsp_gen, pop})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      en_q   <= 1'b0;
      we_q   <= '0;
      addr_q <= '0;
      din_q  <= '0;
      iss_q  <= 1'b0;
      pipe_q <= '0;
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
`ifdef XPMWRAP_RAM_PORT_CTRL_WR_ACK_EN
      iss_wr_q  <= 1'b0;
      pipe_wr_q <= '0;
      memwr_q   <= '0;
`endif
    end else begin
      en_q   <= en_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      iss_q  <= iss_d;
      pipe_q <= pipe_d;
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
`ifdef XPMWRAP_RAM_PORT_CTRL_WR_ACK_EN
      iss_wr_q  <= iss_wr_d;
      pipe_wr_q <= pipe_wr_d;
      memwr_q   <= memwr_d;
`endif
    end
  end

endmodule

// File: tb/tb_xpmwrap_ram_port_ctrl.sv
// Bench for xpmwrap_ram_port_ctrl: behavioural RAM plus a shadow-memory / expected-response
// queue model; honours XPMWRAP_RAM_PORT_CTRL_WR_ACK_EN like the design.
`timescale 1ns/1ps
module tb_xpmwrap_ram_port_ctrl;

  logic        clka = 1'b0;
  logic        rsta;
  logic        req_valid, req_ready, req_we;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_wr;
  logic [31:0] rsp_rdata;
  logic        ram_en, ram_regce, ram_rst;
  logic [3:0]  ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  int n_tests = 0;
  int n_fail  = 0;
  int n_hs    = 0;

  always #5 clka = ~clka;

  xpmwrap_ram_port_ctrl dut (
    .clka      (clka),
    .rsta      (rsta),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_wr    (rsp_wr),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_regce (ram_regce),
    .ram_rst   (ram_rst),
    .ram_dout  (ram_dout)
  );

  // Two-cycle-latency byte-write RAM standing in for the XPM primitive.
  logic [31:0] ram_mem [64];
  logic [31:0] ram_s1;
  initial begin
    for (int i = 0; i < 64; i++) ram_mem[i] = '0;
    ram_s1   = '0;
    ram_dout = '0;
  end
  always @(posedge clka) begin
    if (ram_en) begin
      ram_s1 <= ram_mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
    ram_dout <= ram_s1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: shadow memory updated at acceptance, queue of owed responses in order.
  logic [31:0] shadow [64];
  logic [32:0] exp_q [$];
  logic        primed = 1'b0;
  logic        hold_prev = 1'b0;
  logic [32:0] prev_rsp;
  logic        m_en;
  logic [3:0]  m_we;
  logic [5:0]  m_addr;
  logic [31:0] m_din;
  initial for (int i = 0; i < 64; i++) shadow[i] = '0;

  always @(negedge clka) begin
    if (primed) begin
      chk("ram_en", ram_en, m_en);
      chk("ram_we", ram_we, m_we);
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_din", ram_din, m_din);
      chk("ram_regce", ram_regce, 1);
      chk("ram_rst", ram_rst, rsta);
      if (rsta) chk("ready_in_rst", req_ready, 0);
      else begin
        chk("req_ready", req_ready, exp_q.size() < 8);
        if (hold_prev) begin
          chk("hold_valid", rsp_valid, 1);
          chk("hold_data", {rsp_wr, rsp_rdata}, prev_rsp);
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) chk("stale_rsp", rsp_valid, 0);
          else begin
            chk("rsp", {rsp_wr, rsp_rdata}, exp_q[0]);
            if (rsp_ready) begin
              void'(exp_q.pop_front());
              n_hs++;
            end
          end
        end
      end
    end
    if (rsta) begin
      exp_q.delete();
      m_en      = 1'b0;
      m_we      = '0;
      m_addr    = '0;
      m_din     = '0;
      hold_prev = 1'b0;
      primed    = 1'b1;
    end else begin
      hold_prev = rsp_valid && !rsp_ready;
      prev_rsp  = {rsp_wr, rsp_rdata};
      if (req_valid && req_ready) begin
        m_en   = 1'b1;
        m_we   = req_we ? req_be : 4'h0;
        m_addr = req_addr;
        m_din  = req_wdata;
        if (req_we) begin
          for (int b = 0; b < 4; b++)
            if (req_be[b]) shadow[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
`ifdef XPMWRAP_RAM_PORT_CTRL_WR_ACK_EN
          exp_q.push_back({1'b1, 32'h0});
`endif
        end else begin
          exp_q.push_back({1'b0, shadow[req_addr]});
        end
      end else begin
        m_en = 1'b0;
        m_we = '0;
      end
    end
  end

  task automatic issue(input logic we, input logic [5:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    int k = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    @(negedge clka);
    while (!req_ready && k < 100) begin
      @(negedge clka);
      k++;
    end
    chk("issue_timeout", k < 100, 1);
    @(posedge clka);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clka);
      #1;
      k++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clka);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, acc, hs0, ones, first, last;
    rsta      = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clka);
    #1;
    @(negedge clka);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_wr", rsp_wr, 0);
    @(posedge clka);
    #1;
    rsta = 1'b0;
    @(negedge clka);
    chk("ready_after_rst", req_ready, 1);
    @(posedge clka);
    #1;

    // Full write then read: latency 4 and data
    issue(1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
    drain();
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 6'd5;
    @(negedge clka);
    chk("rd_accept", req_ready, 1);
    @(posedge clka);
    #1;
    req_valid = 1'b0;
    @(negedge clka);
    chk("rd_ram_en", ram_en, 1);
    chk("rd_ram_we", ram_we, 0);
    chk("rd_ram_addr", ram_addr, 5);
    k = 1;
    while (!rsp_valid && k < 20) begin
      @(negedge clka);
      k++;
    end
    chk("rd_latency", k, 4);
    chk("rd_data", rsp_rdata, 32'hDEADBEEF);
    chk("rd_wr_flag", rsp_wr, 0);
    drain();

    // Byte-lane merge
    issue(1'b1, 6'd3, 32'h11223344, 4'hF);
    issue(1'b1, 6'd3, 32'hAABBCCDD, 4'b0010);
    drain();
    issue(1'b0, 6'd3, 32'h0, 4'h0);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clka);
      k++;
    end
    chk("be_merge", rsp_rdata, 32'h1122CC44);
    drain();

    // Write acknowledge (or its absence)
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 6'd9;
    req_wdata = 32'hCAFEF00D;
    req_be    = 4'b0101;
    @(negedge clka);
    chk("wr_accept", req_ready, 1);
    @(posedge clka);
    #1;
    req_valid = 1'b0;
    @(negedge clka);
    chk("wr_ram_we", ram_we, 4'b0101);
    chk("wr_ram_din", ram_din, 32'hCAFEF00D);
    k = 1;
    while (!rsp_valid && k < 12) begin
      @(negedge clka);
      k++;
    end
`ifdef XPMWRAP_RAM_PORT_CTRL_WR_ACK_EN
    chk("wrack_latency", k, 4);
    chk("wrack_wr", rsp_wr, 1);
    chk("wrack_data", rsp_rdata, 0);
`else
    chk("wr_no_rsp", rsp_valid, 0);
    chk("wr_no_rsp_wait", k, 12);
`endif
    drain();

    // Backpressure: 10 reads, 8 accepted, then release
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 6'(i);
      req_wdata = $urandom;
      @(negedge clka);
      if (req_ready) acc++;
      @(posedge clka);
      #1;
    end
    req_valid = 1'b0;
    chk("bp_accepted", acc, 8);
    @(negedge clka);
    chk("bp_ready_low", req_ready, 0);
    repeat (6) @(posedge clka);
    #1;
    hs0 = n_hs;
    rsp_ready = 1'b1;
    @(negedge clka);
    chk("bp_first_hs", rsp_valid, 1);
    @(negedge clka);
    chk("bp_ready_back", req_ready, 1);
    @(posedge clka);
    #1;
    drain();
    chk("bp_rsp_count", n_hs - hs0, 8);

    // Streaming: 16 consecutive reads of random data
    for (int i = 0; i < 16; i++) issue(1'b1, 6'(i), $urandom, 4'hF);
    drain();
    ones  = 0;
    first = -1;
    last  = -1;
    for (int i = 0; i < 24; i++) begin
      if (i < 16) begin
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 6'(i);
      end else req_valid = 1'b0;
      @(negedge clka);
      if (i < 16) chk("stream_ready", req_ready, 1);
      if (rsp_valid) begin
        ones++;
        if (first < 0) first = i;
        last = i;
      end
      @(posedge clka);
      #1;
    end
    req_valid = 1'b0;
    chk("stream_count", ones, 16);
    chk("stream_first", first, 4);
    chk("stream_last", last, 19);
    drain();

    // Reset with reads in flight
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 6'(i);
      @(posedge clka);
      #1;
    end
    req_valid = 1'b0;
    rsta      = 1'b1;
    @(posedge clka);
    #1;
    rsta = 1'b0;
    @(negedge clka);
    chk("inflight_rst_valid", rsp_valid, 0);
    chk("inflight_rst_en", ram_en, 0);
    chk("inflight_rst_ready", req_ready, 1);
    k = 0;
    repeat (10) begin
      @(negedge clka);
      if (rsp_valid) k++;
    end
    chk("inflight_no_stale", k, 0);
    @(posedge clka);
    #1;

    // Random traffic on a small address range to stress same-address hazards
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = 6'($urandom_range(0, 7));
      req_wdata = $urandom;
      req_be    = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clka);
      #1;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
